uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the board's DIP-switch UART transmitter: it consumes the 8N1 line driven on the TX board's `RX` pin and recovers each byte. It uses 8x oversampling, mid-bit majority-free sampling, glitch rejection on the start bit, and stop-bit checking. It presents a one-cycle valid pulse plus a held copy of the last good byte for the IO board LEDs.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `BAUD`, 9600, line bit rate
- `OVERSAMPLE`, 8, sample ticks per bit (power of two, at least 4)
- `M_CLOCK` input 1, FPGA clock; all logic on its rising edge
- `M_RESET_N` input 1, asynchronous, active-low reset
- `RX_IN` input 1, asynchronous serial line, idle high
- `DATA_OUT` output 8, last received byte
- `DATA_VALID` output 1, one-cycle pulse when `DATA_OUT` is updated
- `FRAME_ERR` output 1, one-cycle pulse when the stop bit is sampled low
- `PARITY_ERR` output 1, one-cycle pulse on parity mismatch; constant 0 without the macro
- `BUSY` output 1, high whenever the state is not IDLE
- `IO_LED` output 8, last good byte, held for display

## Operation
- `RX_IN` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- The tick generator divides `M_CLOCK` by `DIV = CLK_HZ/(BAUD*OVERSAMPLE)`, rounded to nearest. The default gives 651. The generator is free-running and produces a one-cycle `tick` every `DIV` clocks.
- The FSM advances only on `tick`. A 3-bit sample counter `sc` and a 3-bit bit index `bi` count within the FSM.
- IDLE: on a tick with `rxs==0`, go to START with `sc=0`.
- START: when `sc==OVERSAMPLE/2-1`, the FSM checks `rxs`.
  - If `rxs==1`, it is a glitch; return to IDLE with no output.
  - If `rxs==0`, set `sc=0`, `bi=0`, and go to DATA.
- DATA: when `sc==OVERSAMPLE-1`, shift `rxs` into the shift register LSB-first. After bit 7, go to STOP, or to PARITY under the macro.
- STOP: sample at `sc==OVERSAMPLE-1`.
  - If `rxs==1` and there is no parity error, load `DATA_OUT` and `IO_LED` and pulse `DATA_VALID`, then go to IDLE.
  - If `rxs==0`, pulse `FRAME_ERR`, leave `DATA_OUT` and `IO_LED` unchanged, and go to RECOVER.
- RECOVER: wait for a tick with `rxs==1`, then go to IDLE. A held-low break line therefore produces exactly one `FRAME_ERR`.
- Output pulses are registered. `DATA_VALID` and `FRAME_ERR` are never high in the same cycle.

## Timing
- Reset values:
  - `DATA_OUT=0`, `IO_LED=0`, `DATA_VALID=0`, `FRAME_ERR=0`, `PARITY_ERR=0`, `BUSY=0`
  - state IDLE, tick counter 0
- Start-edge detection resolution is 1 tick, i.e. 1/8 bit. Each sample point lies in the middle of its bit, within ±1/16 bit.
- Latency from the falling edge on `RX_IN` to `DATA_VALID` is about 9.5 bit times, plus 2 sync cycles, plus up to 1 tick, plus 1 clock. The macro adds 1 bit time.
- Back-to-back frames: IDLE is re-entered in the mid-stop-bit tick. A start bit immediately following the stop bit is therefore detected.
- Reset asserted mid-frame aborts immediately and gives no pulse. The first full frame after release is received correctly.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is inserted after the data bits and samples one even-parity bit.
  - On a mismatch, `PARITY_ERR` pulses with the stop-bit decision and `DATA_VALID` is suppressed.
  - A frame with both a parity mismatch and a low stop bit pulses both `PARITY_ERR` and `FRAME_ERR`, then enters RECOVER.
- Undefined: 8N1 only, the PARITY state does not exist, and `PARITY_ERR` is tied to 0.

## Structure
- Package `uart_pkg`:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, RECOVER)
  - the default `CLK_HZ`/`BAUD` constants
  - a constant function for `DIV`, shared with the transmitter's 5208 bit divider
- Sub-module `uart_baud_tick`:
  - parameter `DIV`, ports `M_CLOCK`, `M_RESET_N`, output `tick`
  - the receiver instantiates it once

## Test plan
- Send 0xA5 at 9600 baud → exactly one `DATA_VALID`, `DATA_OUT`=`IO_LED`=0xA5, `FRAME_ERR`=0, `BUSY` low afterwards.
- Low pulse of 2 ticks on an idle line → `BUSY` high briefly, no pulses, `DATA_OUT` unchanged.
- 0x3C with the stop bit driven low, followed by the line going high → one `FRAME_ERR`, `DATA_OUT` holds its previous value, IDLE is reached, and a following 0x81 is received.
- Back-to-back 0x00 then 0xFF with no idle gap → two `DATA_VALID` pulses carrying 0x00 then 0xFF.
- Assert `M_RESET_N` low during bit 4 of 0x5A, release, then send 0xC3 → all outputs are 0 during reset, then one `DATA_VALID` with 0xC3.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong; 0x07 needs parity 1) → `PARITY_ERR` pulse and no `DATA_VALID`; the same byte with parity 1 → `DATA_VALID` with 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default clock/baud constants
// and the rounding divider function also used by the transmitter's bit divider.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      RECOVER
   } uart_rx_state_t;

   localparam int CLK_HZ_DEFAULT = 50_000_000;
   localparam int BAUD_DEFAULT   = 9600;

   // Clocks per event, rounded to nearest: 651 for 9600x8 at 50 MHz, 5208 for 9600.
   function automatic int calc_div(input int clk_hz, input int rate);
      return (clk_hz + rate / 2) / rate;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and result bundle of the UART receiver; the receiver takes the
// slave view, whoever drives the line and watches the results takes the master view.
interface uart_rx_if;

   logic       RX_IN;
   logic [7:0] DATA_OUT;
   logic       DATA_VALID;
   logic       FRAME_ERR;
   logic       PARITY_ERR;
   logic       BUSY;
   logic [7:0] IO_LED;

   modport master (
      output RX_IN,
      input  DATA_OUT, DATA_VALID, FRAME_ERR, PARITY_ERR, BUSY, IO_LED
   );

   modport slave (
      input  RX_IN,
      output DATA_OUT, DATA_VALID, FRAME_ERR, PARITY_ERR, BUSY, IO_LED
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks, counter starts at 0 on reset.
module uart_baud_tick #(
   parameter int DIV = 651
) (
   input  logic M_CLOCK,
   input  logic M_RESET_N,
   output logic tick
);

   localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]   LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N)       cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 8x oversampled, mid-bit sampling with start-glitch rejection.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = CLK_HZ_DEFAULT,
   parameter int BAUD       = BAUD_DEFAULT,
   parameter int OVERSAMPLE = 8
) (
   input logic      M_CLOCK,
   input logic      M_RESET_N,
   uart_rx_if.slave bus
);

   localparam int            DIV     = calc_div(CLK_HZ, BAUD * OVERSAMPLE);
   localparam int            SW      = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);

   logic tick;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .M_CLOCK  (M_CLOCK),
      .M_RESET_N(M_RESET_N),
      .tick     (tick)
   );

   // Two-flop synchronizer, reset to the idle (high) line level.
   logic [1:0] sync_q;
   logic       rxs;

   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N) sync_q <= 2'b11;
      else            sync_q <= {sync_q[0], bus.RX_IN};
   end

   assign rxs = sync_q[1];

   uart_rx_state_t state, state_n;
   logic [SW-1:0]  sc, sc_n;
   logic [2:0]     bi, bi_n;
   logic [7:0]     shift, shift_n;
   logic           load, ferr_set;
   logic [7:0]     data_q, led_q;
   logic           valid_q, ferr_q;
   logic           par_bad;
`ifdef UART_RX_PARITY_EN
   logic           par_bad_q, par_bad_n, perr_set, perr_q;
   assign par_bad = par_bad_q;
`else
   assign par_bad = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_n  = state;
      sc_n     = sc;
      bi_n     = bi;
      shift_n  = shift;
      load     = 1'b0;
      ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad_q;
      perr_set  = 1'b0;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state_n = START;
                  sc_n    = '0;
               end
            end
            START: begin
               if (sc == SC_MID) begin
                  if (rxs) begin
                     state_n = IDLE;
                  end else begin
                     sc_n    = '0;
                     bi_n    = 3'd0;
                     state_n = DATA;
                  end
               end else begin
                  sc_n = sc + SW'(1);
               end
            end
            DATA: begin
               if (sc == SC_LAST) begin
                  shift_n = {rxs, shift[7:1]};
                  sc_n    = '0;
                  if (bi == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     bi_n = bi + 3'd1;
                  end
               end else begin
                  sc_n = sc + SW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sc == SC_LAST) begin
                  par_bad_n = (^shift) != rxs;
                  sc_n      = '0;
                  state_n   = STOP;
               end else begin
                  sc_n = sc + SW'(1);
               end
            end
`endif
            STOP: begin
               if (sc == SC_LAST) begin
                  sc_n = '0;
`ifdef UART_RX_PARITY_EN
                  perr_set = par_bad_q;
`endif
                  if (rxs) begin
                     load    = !par_bad;
                     state_n = IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_n  = RECOVER;
                  end
               end else begin
                  sc_n = sc + SW'(1);
               end
            end
            RECOVER: begin
               // Hold here while the line stays low so a break reports only once.
               if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N) begin
         state   <= IDLE;
         sc      <= '0;
         bi      <= 3'd0;
         shift   <= 8'h00;
         data_q  <= 8'h00;
         led_q   <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         sc      <= sc_n;
         bi      <= bi_n;
         shift   <= shift_n;
         valid_q <= load;
         ferr_q  <= ferr_set;
         if (load) begin
            data_q <= shift;
            led_q  <= shift;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
      if (!M_RESET_N) begin
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         par_bad_q <= par_bad_n;
         perr_q    <= perr_set;
      end
   end
   assign bus.PARITY_ERR = perr_q;
`else
   assign bus.PARITY_ERR = 1'b0;
`endif

   assign bus.DATA_OUT   = data_q;
   assign bus.IO_LED     = led_q;
   assign bus.DATA_VALID = valid_q;
   assign bus.FRAME_ERR  = ferr_q;
   assign bus.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a line driver pushes the expected outcome of each
// frame, a monitor pops and compares on every DATA_VALID/FRAME_ERR/PARITY_ERR pulse.
module tb_uart_rx;

   localparam int CLK_HZ = 320_000;
   localparam int BAUD   = 10_000;
   localparam int OS     = 8;
   localparam int BIT    = CLK_HZ / BAUD;   // clocks per bit
   localparam int TICK   = BIT / OS;        // clocks per oversample tick

   typedef struct {
      bit         valid;
      bit         ferr;
      bit         perr;
      logic [7:0] out;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
      .M_CLOCK  (clk),
      .M_RESET_N(rst_n),
      .bus      (bus.slave)
   );

   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every output pulse must match the oldest expected frame outcome.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (bus.DATA_VALID || bus.FRAME_ERR || bus.PARITY_ERR)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {29'd0, bus.DATA_VALID, bus.FRAME_ERR, bus.PARITY_ERR}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("data_valid", bus.DATA_VALID, e.valid);
               check("frame_err", bus.FRAME_ERR, e.ferr);
               check("parity_err", bus.PARITY_ERR, e.perr);
               check("data_out", bus.DATA_OUT, e.out);
               check("io_led", bus.IO_LED, e.out);
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      bus.RX_IN = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic idle(input int bits);
      bus.RX_IN = 1'b1;
      repeat (bits * BIT) @(negedge clk);
   endtask

   // Reference: a frame is good iff stop is high and (with parity) the bit count is even.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
      ev_t e;
      bit  par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_ok = ((^d) == par_bit);
`endif
      e.valid = stop_bit && par_ok;
      e.ferr  = !stop_bit;
      e.perr  = !par_ok;
      if (e.valid) last_good = d;
      e.out = last_good;
      exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 20 * BIT) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_out"}, bus.DATA_OUT, 0);
      check({tag, "_io_led"}, bus.IO_LED, 0);
      check({tag, "_data_valid"}, bus.DATA_VALID, 0);
      check({tag, "_frame_err"}, bus.FRAME_ERR, 0);
      check({tag, "_parity_err"}, bus.PARITY_ERR, 0);
      check({tag, "_busy"}, bus.BUSY, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         saw_busy;
      logic [7:0] d, d5a;
      logic       stop, par;
      int         gap;

      bus.RX_IN = 1'b1;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Single good byte
      send_frame(8'hA5, 1'b1, ^8'hA5);
      idle(1);
      wait_drain("drain_a5");
      check("busy_after_a5", bus.BUSY, 0);

      // Two-tick glitch: BUSY blips, no pulse, outputs hold
      saw_busy = 1'b0;
      bus.RX_IN = 1'b0;
      for (int i = 0; i < 2 * BIT; i++) begin
         if (i == 2 * TICK) bus.RX_IN = 1'b1;
         @(negedge clk);
         if (bus.BUSY) saw_busy = 1'b1;
      end
      check("glitch_busy_seen", saw_busy, 1);
      check("glitch_busy_end", bus.BUSY, 0);
      check("glitch_data_hold", bus.DATA_OUT, last_good);

      // Framing error, then recovery and a good byte
      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle(2);
      send_frame(8'h81, 1'b1, ^8'h81);
      idle(1);
      wait_drain("drain_ferr");

      // Break line: held low well past the stop bit, exactly one FRAME_ERR
      send_frame(8'h00, 1'b0, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      idle(2);
      wait_drain("drain_break");

      // Back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      idle(1);
      wait_drain("drain_b2b");

      // Reset during bit 4 of 0x5A, then 0xC3
      d5a = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
      bus.RX_IN = d5a[4];
      repeat (BIT / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("mid_reset");
      exp_q.delete();
      last_good = 8'h00;
      bus.RX_IN = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      send_frame(8'hC3, 1'b1, ^8'hC3);
      idle(1);
      wait_drain("drain_after_reset");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      idle(1);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(1);
      send_frame(8'h07, 1'b0, 1'b0);
      idle(2);
      wait_drain("drain_parity");
`endif

      // Randomized frames with random gaps, occasional bad stop (and parity) bits
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         par  = (^d) ^ ($urandom_range(0, 4) == 0);
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         send_frame(d, stop, par);
         if (gap > 0) idle(gap);
      end
      idle(1);
      wait_drain("drain_random");
      check("busy_final", bus.BUSY, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
